// File: rtl/req_agent_pkg.sv
// Shared defaults for the request agent: port count, pending-counter width,
// starvation threshold and wait-counter width.
package req_agent_pkg;

  localparam int DEF_NUM_PORTS    = 17;
  localparam int DEF_CNT_W        = 4;
  localparam int DEF_STARVE_LIMIT = 15;
  localparam int WAIT_W           = 8;

endpackage

// File: rtl/req_agent_port.sv
// One requester lane: pending-request counter, grant acceptance, served pulse,
// starvation wait counter and sticky overflow flag.
module req_agent_port
  import req_agent_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             gnt,
  output logic             req,
  output logic [CNT_W-1:0] cnt,
  output logic             served,
  output logic             starve,
  output logic             ovf
);

  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  cnt_q;
  logic [WAIT_W-1:0] wcnt_q;
  logic              take;
  logic              full;
  logic              push_ok;
  logic              drop;

  assign req     = (cnt_q != '0);
  assign take    = gnt & req;
  assign full    = (cnt_q == CNT_MAX);
  // A grant in the same cycle frees a slot, so a push at max still lands.
  assign push_ok = push & (~full | take);
  assign drop    = push & full & ~take;
  assign cnt     = cnt_q;
  assign starve  = (wcnt_q == WAIT_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      wcnt_q <= '0;
      served <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok && !take) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (take && !push_ok) begin
        cnt_q <= cnt_q - 1'b1;
      end
      served <= take;
      if (drop) begin
        ovf <= 1'b1;
      end
      if (take || !req) begin
        wcnt_q <= '0;
      end else if (wcnt_q != WAIT_LIMIT) begin
        wcnt_q <= wcnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_agent.sv
// Request agent in front of a fixed-priority arbiter: queues per-port request
// pulses, drives request levels and checks the returned grant vector.
module req_agent
  import req_agent_pkg::*;
#(
  parameter int NUM_PORTS    = DEF_NUM_PORTS,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_PORTS-1:0]       push_i,
  output logic [NUM_PORTS-1:0]       req_o,
  input  logic [NUM_PORTS-1:0]       gnt_i,
  output logic [NUM_PORTS-1:0]       served_o,
  output logic [NUM_PORTS*CNT_W-1:0] pend_cnt_o,
  output logic [NUM_PORTS-1:0]       starve_o,
  output logic [NUM_PORTS-1:0]       ovf_o,
  output logic                       err_o
);

  logic multi_hot;
  logic idle_gnt;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    req_agent_port #(
      .CNT_W        (CNT_W),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_port (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_i[i]),
      .gnt     (gnt_i[i]),
      .req     (req_o[i]),
      .cnt     (pend_cnt_o[i*CNT_W +: CNT_W]),
      .served  (served_o[i]),
      .starve  (starve_o[i]),
      .ovf     (ovf_o[i])
    );
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(gnt_i & (gnt_i - 1'b1));
  assign idle_gnt  = |(gnt_i & ~req_o);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_o <= 1'b0;
    end else if (multi_hot || idle_gnt) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: doc/req_agent.md
REQ_AGENT -- requirements
Module: req_agent

Interface
REQ-001 Parameter NUM_PORTS, default 17, number of requester ports; SHALL be >= 2.
REQ-002 Parameter CNT_W, default 4, width of each per-port pending counter; max pending = 2**CNT_W-1.
REQ-003 Parameter STARVE_LIMIT, default 15, cycles of un-granted request before starvation flag; SHALL fit in 8 bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 push_i  input  NUM_PORTS  per-port client request event, one pulse = one queued request.
REQ-007 req_o  output  NUM_PORTS  per-port request level driven toward the fixed-priority arbiter (day14 req_i).
REQ-008 gnt_i  input  NUM_PORTS  grant vector from arbiter (day14 gnt_o), expected one-hot or zero, may be combinational from req_o.
REQ-009 served_o  output  NUM_PORTS  per-port one-cycle pulse: one queued request was granted.
REQ-010 pend_cnt_o  output  NUM_PORTS*CNT_W  flat per-port pending counts, port i at bits [i*CNT_W +: CNT_W].
REQ-011 starve_o  output  NUM_PORTS  per-port level: port has waited STARVE_LIMIT cycles without grant.
REQ-012 ovf_o  output  NUM_PORTS  per-port sticky: a push was dropped at full count.
REQ-013 err_o  output  1  sticky: illegal grant (multi-hot, or grant to a port with req_o low).

Function
REQ-014 Each port SHALL hold a CNT_W-bit pending counter cnt[i]; pend_cnt_o SHALL equal the registered cnt values.
REQ-015 req_o[i] SHALL be 1 exactly when registered cnt[i] != 0 (no combinational path from push_i or gnt_i).
REQ-016 Accepted grant: gnt_i[i] && req_o[i] in cycle N; cnt[i] SHALL decrement by 1 at edge N+1 and served_o[i] SHALL be 1 for cycle N+1 only.
REQ-017 Accepted push: push_i[i] && cnt[i] != max in cycle N; cnt[i] SHALL increment at edge N+1; req_o[i] first rises in N+1.
REQ-018 Simultaneous accepted push and grant on one port SHALL leave cnt[i] unchanged; served_o[i] still pulses.
REQ-019 Push at cnt[i] == max with no same-cycle accepted grant SHALL be dropped and set ovf_o[i]; push at max with accepted grant SHALL be accepted (count stays max).
REQ-020 Grant on a port with req_o low SHALL be ignored (no decrement, no served pulse) and SHALL set err_o.
REQ-021 More than one bit set in gnt_i SHALL set err_o; each set bit with req_o high SHALL still be accepted per REQ-016.
REQ-022 Per-port wait counter (8 bits) SHALL increment each cycle req_o[i]=1 and no accepted grant, saturating at STARVE_LIMIT; SHALL clear to 0 on accepted grant or when req_o[i]=0.
REQ-023 starve_o[i] SHALL be 1 while wait counter == STARVE_LIMIT; clears the cycle after the clearing grant.
REQ-024 ovf_o and err_o SHALL stay set until reset.

Reset
REQ-025 reset_n low SHALL asynchronously clear all cnt, wait counters, served_o, starve_o, ovf_o, err_o; req_o and pend_cnt_o read 0.
REQ-026 Reset mid-operation SHALL discard all pending requests; no served_o pulse SHALL follow reset release until a new push is granted.
REQ-027 First state update SHALL be the first rising clk edge after reset_n deasserts.

Structure
REQ-028 Package req_agent_pkg SHALL hold default NUM_PORTS, CNT_W, STARVE_LIMIT constants and the wait-counter width.
REQ-029 Per-port logic (counter, wait counter, served, starve, ovf) SHALL be sub-module req_agent_port, instantiated NUM_PORTS times via generate; err_o and multi-hot check at top level.

Verification
REQ-030 Bench SHALL connect req_agent to day14 with NUM_PORTS=17 via a shared interface and cover:
REQ-031 Single push on port 5 -> req_o[5]=1 next cycle, gnt accepted, served_o[5] pulse one cycle later, cnt[5] back to 0.
REQ-032 Simultaneous pushes on ports 0 and 16 -> port 0 served first, port 16 served next cycle, both counts 0 after 2 grants.
REQ-033 16 pushes on port 3 with CNT_W=4 while req held off -> cnt=15, 16th push dropped, ovf_o[3]=1, exactly 15 served pulses after release.
REQ-034 Port 0 pushed continuously while port 9 has 1 pending -> starve_o[9]=1 after 15 cycles.
REQ-035 Forced gnt_i=17'h00011 and grant on idle port -> err_o=1, idle port count unchanged.
REQ-036 reset_n pulsed low with cnt[2]=7 mid-cycle -> all outputs 0 immediately, no served_o afterwards.
